// File: rtl/bd_downstream_arbiter.sv
// Round-robin arbiter that forwards one word at a time from NUM_PORTS requesters
// to the BD using a four-phase req/xe handshake. Decisions use the synchronized xe.
module bd_downstream_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 21,
  parameter int TIMEOUT   = 1023,
  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       _Reset,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]       in_ready,
  input  logic [NUM_PORTS-1:0]       port_en,
  output logic                       req,
  output logic [WIDTH-1:0]           x,
  input  logic                       xe,
  output logic [PW-1:0]              grant_id,
  output logic                       timeout_err,
  input  logic                       err_clr,
  output logic                       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETUP    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_xe_meta;
  logic                 r_xe_s;
  logic                 r_req;
  logic [WIDTH-1:0]     r_x;
  logic [PW-1:0]        r_gid;
  logic [PW-1:0]        r_rr_ptr;
  logic [CW-1:0]        r_cnt;
  logic                 r_err;
  logic [NUM_PORTS-1:0] w_elig;
  logic                 w_found;
  logic [PW-1:0]        w_gnt;
  logic                 w_xfer;
  logic                 w_to_hit;

  // xe comes from the BD clock domain
  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      r_xe_meta <= 1'b0;
      r_xe_s    <= 1'b0;
    end else begin
      r_xe_meta <= xe;
      r_xe_s    <= r_xe_meta;
    end
  end

  // First eligible port strictly after the last winner, wrapping around
  always_comb begin
    int cand;
    cand    = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    w_elig  = in_valid & port_en;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = (int'(r_rr_ptr) + i) % NUM_PORTS;
      if (!w_found && w_elig[cand]) begin
        w_found = 1'b1;
        w_gnt   = PW'(cand);
      end
    end
  end

  assign w_xfer   = (r_state == S_IDLE) && r_xe_s && w_found;
  assign in_ready = w_xfer ? (NUM_PORTS'(1) << w_gnt) : '0;
  assign w_to_hit = (r_state == S_WAIT_ACK) && r_xe_s && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_xfer)  w_state_nxt = S_SETUP;
      S_SETUP:                 w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (!r_xe_s) w_state_nxt = S_WAIT_REL;
      S_WAIT_REL: if (r_xe_s)  w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      r_req    <= 1'b0;
      r_x      <= '0;
      r_gid    <= '0;
      r_rr_ptr <= PW'(NUM_PORTS - 1);
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_x      <= in_data[int'(w_gnt)*WIDTH +: WIDTH];
        r_gid    <= w_gnt;
        r_rr_ptr <= w_gnt;
      end
      if (r_state == S_SETUP) begin
        r_req <= 1'b1;
        r_cnt <= '0;
      end else if (r_state == S_WAIT_ACK) begin
        if (!r_xe_s) r_req <= 1'b0;
        else if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
      end
      // A timeout in the same cycle as err_clr must not be lost
      if (w_to_hit)     r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign req         = r_req;
  assign x           = r_x;
  assign grant_id    = r_gid;
  assign timeout_err = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
